// File: rtl/bin2qdi_pkg.sv
// Shared types and helpers for the binary to 1-of-N QDI transmitter.
package bin2qdi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RTZ   = 2'd2
  } state_e;

  // Widest digit the decode helper can represent.
  localparam int MAX_RAILS = 64;

  typedef struct packed {
    logic                 legal;
    logic [MAX_RAILS-1:0] oh;
  } dec_t;

  // Bits needed to carry one binary digit of an N-rail code.
  function automatic int cw_f(input int n_rails);
    return (n_rails < 2) ? 1 : $clog2(n_rails);
  endfunction

  // Total binary word width.
  function automatic int dw_f(input int n_rails, input int digits);
    return digits * cw_f(n_rails);
  endfunction

  // One-hot decode of a binary digit; values >= n_rails decode to all-zero and legal=0.
  function automatic dec_t onehot_dec(input logic [31:0] v, input int n_rails);
    dec_t d;
    d       = '0;
    d.legal = (v < $unsigned(n_rails));
    if (d.legal) d.oh[v[5:0]] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/bin2qdi_1ofn_tx_fifo.sv
// qdi_sync_fifo: circular-buffer synchronous FIFO with occupancy counter.
module qdi_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNTW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap at DEPTH; counter holds on simultaneous push and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_nxt(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bin2qdi_1ofn_tx.sv
// bin2qdi_1ofn_tx: buffers binary words and drives DIGITS parallel 1-of-N
// four-phase QDI digits, completing on a shared asynchronous enable Re.
// Optional watchdog: define BIN2QDI_TIMEOUT_EN.
module bin2qdi_1ofn_tx
  import bin2qdi_pkg::*;
#(
  parameter  int N_RAILS     = 3,
  parameter  int DIGITS      = 1,
  parameter  int DEPTH       = 2,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CW          = cw_f(N_RAILS),
  localparam int DW          = dw_f(N_RAILS, DIGITS),
  localparam int RW          = DIGITS * N_RAILS
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [RW-1:0] R,
  input  logic          Re,
  output logic          busy,
  output logic          err_code,
  output logic          timeout_err,
  inout  wire           VDD,
  inout  wire           GND
);

  localparam int CNTW = $clog2(DEPTH + 1);

  logic [RW-1:0]          din_oh, fifo_head;
  logic [DIGITS-1:0]      dig_ok;
  logic                   word_legal, accept, push, pop;
  logic                   fifo_full, fifo_empty;
  logic [CNTW-1:0]        fifo_cnt;
  logic [SYNC_STAGES-1:0] re_sync_q, re_sync_d;
  logic                   re_s;
  state_e                 state_q, state_d;
  logic [RW-1:0]          r_q, r_d;
  logic                   err_q;
  logic                   unused_pwr;

  assign unused_pwr = VDD ^ GND;

  // Per-digit decode; the FIFO stores words already in rail form.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    dec_t dec;
    logic unused_hi;
    assign dec                           = onehot_dec(32'(din[k*CW +: CW]), N_RAILS);
    assign dig_ok[k]                     = dec.legal;
    assign din_oh[k*N_RAILS +: N_RAILS]  = dec.oh[N_RAILS-1:0];
    assign unused_hi                     = |dec.oh;
  end

  assign word_legal = &dig_ok;
  assign din_ready  = ~RESET & ~fifo_full;
  assign accept     = din_valid & din_ready;
  assign push       = accept & word_legal;

  qdi_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .data_i  (din_oh),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign re_sync_d = (re_sync_q << 1) | SYNC_STAGES'(Re);
  assign re_s      = re_sync_q[SYNC_STAGES-1];

  // Four-phase sequencing: rise from IDLE, fall on Re low, one IDLE cycle of neutral.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        r_d = '0;
        if (!fifo_empty && re_s) begin
          pop     = 1'b1;
          r_d     = fifo_head;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!re_s) begin
          r_d     = '0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        r_d = '0;
        if (re_s) state_d = IDLE;
      end
      default: begin
        r_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, rails, synchroniser and illegal-code pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      r_q       <= '0;
      re_sync_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      re_sync_q <= re_sync_d;
      err_q     <= accept & ~word_legal;
    end
  end

  assign R        = r_q;
  assign err_code = err_q;
  assign busy     = (state_q != IDLE) || (fifo_cnt != '0);

`ifdef BIN2QDI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q;

  // Count cycles spent in one handshake phase; any state change restarts it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE || state_d != state_q) tmo_cnt_d = '0;
    else if (tmo_cnt_q != TW'(TIMEOUT_CYC))    tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_cnt_d == TW'(TIMEOUT_CYC)) tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC == 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin2qdi_1ofn_tx.sv
// Directed bench for bin2qdi_1ofn_tx: a 1-of-3 single-digit instance and a
// 1-of-4 two-digit instance sharing clock, reset and Re.
module tb_bin2qdi_1ofn_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       re;
  logic [1:0] din3;
  logic       val3;
  logic       rdy3, busy3, err3, tmo3;
  logic [2:0] r3;
  logic [3:0] din4;
  logic       val4;
  logic       rdy4, busy4, err4, tmo4;
  logic [7:0] r4;
  wire        vdd_w, gnd_w;

  assign vdd_w = 1'b1;
  assign gnd_w = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef BIN2QDI_TIMEOUT_EN
  localparam logic EXP_TMO = 1'b1;
`else
  localparam logic EXP_TMO = 1'b0;
`endif

  always #5 clk = ~clk;

  bin2qdi_1ofn_tx #(.N_RAILS(3), .DIGITS(1), .DEPTH(2), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) u_dut3 (
    .CLK(clk), .RESET(rst), .din(din3), .din_valid(val3), .din_ready(rdy3), .R(r3),
    .Re(re), .busy(busy3), .err_code(err3), .timeout_err(tmo3), .VDD(vdd_w), .GND(gnd_w)
  );

  bin2qdi_1ofn_tx #(.N_RAILS(4), .DIGITS(2), .DEPTH(2), .SYNC_STAGES(2)) u_dut4 (
    .CLK(clk), .RESET(rst), .din(din4), .din_valid(val4), .din_ready(rdy4), .R(r4),
    .Re(re), .busy(busy4), .err_code(err4), .timeout_err(tmo4), .VDD(vdd_w), .GND(gnd_w)
  );

  typedef struct {
    logic [1:0] din;
    logic [2:0] r;
    logic       err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One clock; a word offered with ready high is taken at this edge, so drop valid.
  task automatic tick();
    logic acc3, acc4;
    acc3 = val3 && rdy3;
    acc4 = val4 && rdy4;
    @(posedge clk);
    #1;
    if (acc3) val3 = 1'b0;
    if (acc4) val4 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for R3 to become nonzero (nz=1) or zero (nz=0).
  task automatic wait_r3(input bit nz, input string nm);
    int n;
    n = 0;
    while (((r3 != 3'b0) != nz) && n < 20) begin
      tick();
      n++;
    end
    check(nm, 32'(r3 != 3'b0), 32'(nz));
  endtask

  task automatic deliver(input logic [2:0] exp, input string nm);
    re = 1'b1;
    wait_r3(1'b1, {nm, "_rise"});
    check(nm, 32'(r3), 32'(exp));
    re = 1'b0;
    wait_r3(1'b0, {nm, "_fall"});
  endtask

  initial begin
    logic seen;
    vecs[0] = '{din: 2'b00, r: 3'b001, err: 1'b0};
    vecs[1] = '{din: 2'b01, r: 3'b010, err: 1'b0};
    vecs[2] = '{din: 2'b10, r: 3'b100, err: 1'b0};
    vecs[3] = '{din: 2'b11, r: 3'b000, err: 1'b1};

    rst = 1'b1; re = 1'b0; din3 = '0; val3 = 1'b0; din4 = '0; val4 = 1'b0;
    #1;
    ticks(3);
    check("rst_R", 32'(r3), 0);
    check("rst_ready", 32'(rdy3), 0);
    check("rst_busy", 32'(busy3), 0);
    check("rst_err", 32'(err3), 0);
    check("rst_tmo", 32'(tmo3), 0);
    check("rst_R4", 32'(r4), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy3), 1);
    re = 1'b1;
    ticks(4);

    // Single-digit decode and full four-phase cycle per vector.
    for (int i = 0; i < 4; i++) begin
      din3 = vecs[i].din;
      val3 = 1'b1;
      tick();
      check($sformatf("v%0d_err", i), 32'(err3), 32'(vecs[i].err));
      check($sformatf("v%0d_R_t", i), 32'(r3), 0);
      tick();
      check($sformatf("v%0d_R", i), 32'(r3), 32'(vecs[i].r));
      if (vecs[i].err) begin
        check($sformatf("v%0d_err_once", i), 32'(err3), 0);
        check($sformatf("v%0d_busy", i), 32'(busy3), 0);
      end else begin
        re = 1'b0;
        ticks(2);
        check($sformatf("v%0d_R_hold", i), 32'(r3), 32'(vecs[i].r));
        tick();
        check($sformatf("v%0d_R_fall", i), 32'(r3), 0);
        re = 1'b1;
        ticks(4);
        check($sformatf("v%0d_idle", i), 32'(busy3), 0);
      end
    end

    // Two digits of 1-of-4: both rise together.
    din4 = 4'b1101;
    val4 = 1'b1;
    tick();
    check("md_R_t", 32'(r4), 0);
    tick();
    check("md_R", 32'(r4), 32'h82);
    check("md_err", 32'(err4), 0);
    re = 1'b0;
    ticks(3);
    check("md_R_fall", 32'(r4), 0);
    re = 1'b1;
    ticks(4);
    check("md_idle", 32'(busy4), 0);

    // Backpressure: Re drops after word 1; words 2 and 3 fill the FIFO.
    din3 = 2'b00; val3 = 1'b1;
    tick();
    re = 1'b0;
    din3 = 2'b01; val3 = 1'b1;
    tick();
    din3 = 2'b10; val3 = 1'b1;
    tick();
    check("bp_w1", 32'(r3), 32'h1);
    check("bp_full_ready", 32'(rdy3), 0);
    din3 = 2'b01; val3 = 1'b1;
    tick();
    check("bp_w4_held", 32'(val3), 1);
    wait_r3(1'b0, "bp_w1_fall");
    deliver(3'b010, "bp_w2");
    check("bp_w4_taken", 32'(val3), 0);
    deliver(3'b100, "bp_w3");
    deliver(3'b010, "bp_w4");
    re = 1'b1;
    ticks(4);
    check("bp_idle", 32'(busy3), 0);

    // Reset while driving with two words buffered.
    din3 = 2'b00; val3 = 1'b1;
    tick();
    din3 = 2'b01; val3 = 1'b1;
    tick();
    din3 = 2'b10; val3 = 1'b1;
    tick();
    check("rm_drive", 32'(r3), 32'h1);
    check("rm_busy_pre", 32'(busy3), 1);
    rst = 1'b1;
    tick();
    check("rm_R", 32'(r3), 0);
    check("rm_busy", 32'(busy3), 0);
    check("rm_ready", 32'(rdy3), 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (r3 != 3'b0) seen = 1'b1;
    end
    check("rm_no_ghost", 32'(seen), 0);
    check("rm_busy_after", 32'(busy3), 0);
    check("rm_ready_after", 32'(rdy3), 1);

    // Watchdog: hold in DRIVE for 20 cycles.
    din3 = 2'b10; val3 = 1'b1;
    ticks(2);
    check("to_drive", 32'(r3), 32'h4);
    check("to_early", 32'(tmo3), 0);
    ticks(20);
    check("to_flag", 32'(tmo3), 32'(EXP_TMO));
    check("to_fsm_hold", 32'(r3), 32'h4);
    rst = 1'b1;
    tick();
    check("to_clear", 32'(tmo3), 0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
